// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter: one-hot registered grant, rotating priority pointer.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, outputs cleared, waiting for any request
// GRANT | one requester owns the resource until done_i (or timeout)
module rr_arbiter_4 #(
  parameter int REQ_CNT  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [REQ_CNT-1:0]         req_i,
  input  logic                       done_i,
  output logic [REQ_CNT-1:0]         gnt_o,
  output logic                       gnt_val_o,
  output logic [$clog2(REQ_CNT)-1:0] gnt_idx_o,
  output logic                       timeout_o
);

  localparam int IDX_W = $clog2(REQ_CNT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_idle;
  logic [IDX_W-1:0] win_rel;
  logic             forced;
  logic             release_now;

  // Lowest request at or above p, falling back to the lowest request overall.
  function automatic logic [IDX_W-1:0] sel_idx(input logic [REQ_CNT-1:0] req,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = REQ_CNT-1; k >= 0; k--)
      if (req[k]) r = IDX_W'(k);
    for (int k = REQ_CNT-1; k >= 0; k--)
      if (req[k] && (k >= int'(p))) r = IDX_W'(k);
    return r;
  endfunction

  function automatic logic [REQ_CNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_CNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_cnt;
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    ptr_next = (gnt_idx_o == IDX_W'(REQ_CNT-1)) ? '0 : gnt_idx_o + IDX_W'(1);
    win_idle = sel_idx(req_i, ptr);
    win_rel  = sel_idx(req_i, ptr_next);
`ifdef ARB_TIMEOUT_EN
    forced   = (hold_cnt == CNT_W'(MAX_HOLD-1)) && !done_i;
`else
    forced   = 1'b0;
`endif
    release_now = done_i || forced;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_o     <= '0;
      gnt_val_o <= 1'b0;
      gnt_idx_o <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
      hold_cnt  <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req_i) begin
            state     <= GRANT;
            gnt_o     <= onehot(win_idle);
            gnt_val_o <= 1'b1;
            gnt_idx_o <= win_idle;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= ptr_next;
`ifdef ARB_TIMEOUT_EN
            timeout_o <= forced;
            hold_cnt  <= '0;
`endif
            // Back-to-back handoff: the next owner is chosen from the advanced pointer.
            if (|req_i) begin
              gnt_o     <= onehot(win_rel);
              gnt_idx_o <= win_rel;
            end else begin
              state     <= IDLE;
              gnt_o     <= '0;
              gnt_val_o <= 1'b0;
              gnt_idx_o <= '0;
            end
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
